load_store_unit: RTL
====================

# load_store_unit

Initiator for the 64-bit byte-banked data memory: accepts one load or store request at a time from the CPU datapath and drives the memory's read/write address, data, write-enable and size (`tam`) inputs. On loads it waits out the memory's fixed read latency, then extracts the addressed doubleword/word/half/byte and sign- or zero-extends it to 64 bits. Sits between the execute stage and the data memory.

## Interface
- `MEM_RD_LAT`, default 1: clock edges from `mem_raddress` stable to `mem_dataout` valid.
- `Clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present; held by the requester until accepted.
- `req_ready` out 1: unit idle and able to accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = doubleword, 01 = word, 10 = half, 11 = byte.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 64: byte address; no alignment requirement.
- `req_wdata` in 64: store data, least-significant bytes used.
- `resp_valid` out 1: one-cycle completion pulse for a load or store.
- `resp_rdata` out 64: extended load data; holds the last load value.
- `mem_raddress` out 64, `mem_waddress` out 64: memory read/write addresses.
- `mem_datain` out 64: memory write data.
- `mem_wr` out 1: memory write enable.
- `mem_tam` out 2: memory access size, same encoding as `req_size`.
- `mem_dataout` in 64: memory read data; byte at `addr+i` is on bits `[8i+7:8i]`.

## Operation
- States: IDLE, STORE, LOAD_WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, register addr, wdata, size, unsigned and we.
  - we=1: go to STORE.
  - we=0: go to LOAD_WAIT with `cnt` = `MEM_RD_LAT`.
- STORE, exactly one cycle: `mem_wr`=1, `mem_waddress`=addr, `mem_datain`=wdata, `mem_tam`=size. Then RESP.
- LOAD_WAIT:
  - `mem_raddress`=addr, held for the whole state.
  - `cnt` decrements each cycle.
  - In the cycle with `cnt`==0, register the extended `mem_dataout` into `resp_rdata` and go to RESP.
- RESP: `resp_valid`=1 for one cycle, then IDLE. The next request is accepted no earlier than the following cycle.
- Extension:
  - size 00: passes all 64 bits.
  - size 01: bits [31:0], extension bit 31.
  - size 10: bits [15:0], extension bit 15.
  - size 11: bits [7:0], extension bit 7.
  - Zero-extend when unsigned=1, sign-extend otherwise.
- Outside STORE: `mem_wr`=0. `mem_raddress`, `mem_waddress`, `mem_datain` and `mem_tam` hold their last registered values.
- `mem_wr` = (state==STORE) && !`reset`, so a reset in the STORE cycle suppresses the write.
- Address wrap-around inside the memory's 16-bit byte space is the memory's behaviour. This unit passes the full 64-bit address through unmodified.
- `req_valid` while `req_ready`=0 is ignored. No queueing.

## Timing
- Reset values:
  - state IDLE; `cnt` 0.
  - `req_ready` 0 while `reset` is high, 1 in the first cycle after release.
  - `resp_valid` 0, `resp_rdata` 0, `mem_wr` 0, `mem_tam` 00.
  - `mem_raddress`, `mem_waddress`, `mem_datain` all 0.
- Store: accepted in cycle N, `mem_wr` high in N+1, `resp_valid` high in N+2.
- Load: accepted in cycle N, LOAD_WAIT covers N+1 .. N+1+`MEM_RD_LAT`, `resp_valid` high in N+2+`MEM_RD_LAT`. With the default, that is N+3.
- `resp_rdata` is valid in the `resp_valid` cycle and stable until the next load's capture.
- Reset mid-operation returns to IDLE at the next edge. The pending operation never produces `resp_valid`.
- Back-to-back throughput: one store per 3 cycles, one load per `MEM_RD_LAT`+3 cycles.

## Structure
- `lsu_pkg`:
  - `size_t` enum: SZ_D=2'b00, SZ_W=2'b01, SZ_H=2'b10, SZ_B=2'b11.
  - `lsu_state_t` enum.
  - `MEM_RD_LAT_DEFAULT` constant.
- Sub-module `load_extend`: combinational; inputs 64-bit raw data, size and unsigned; output 64-bit extended data.
- The FSM, counter and registers stay in `load_store_unit`.

## Test plan
- Hold reset 3 cycles: all outputs 0 and `req_ready`=0. After release, `req_ready`=1 and there is no `resp_valid` without a request.
- Store D 0x1122334455667788 at 0x40, then load D at 0x40:
  - `resp_rdata`=0x1122334455667788.
  - Store `resp_valid` at N+2; load `resp_valid` at N+3.
- Store B 0x80 at 0x41, then three loads:
  - signed B at 0x41 → 0xFFFFFFFFFFFFFF80.
  - unsigned B at 0x41 → 0x0000000000000080.
  - D at 0x40 → 0x1122334455668088.
- Store W 0x80007FFF at 0x80, then four loads:
  - signed H at 0x80 → 0x7FFF.
  - signed H at 0x82 → 0xFFFFFFFFFFFF8000.
  - unsigned W at 0x80 → 0x80007FFF.
  - signed W at 0x80 → 0xFFFFFFFF80007FFF.
- Back-pressure:
  - Hold `req_valid` with a second request through a pending load: it is accepted only in the cycle after RESP.
  - A one-cycle `req_valid` pulse during LOAD_WAIT causes no response.
- Reset in the STORE cycle of a store of 0xAA at 0x10: `mem_wr`=0, and a later load B at 0x10 returns the old value. Reset during LOAD_WAIT: no `resp_valid`.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access size encoding, FSM states and the default memory latency.
// Pure declarations, no logic and no latency.
// No flow control of its own.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_D = 2'b00,
        SZ_W = 2'b01,
        SZ_H = 2'b10,
        SZ_B = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        STORE     = 2'b01,
        LOAD_WAIT = 2'b10,
        RESP      = 2'b11
    } lsu_state_t;

    localparam int MEM_RD_LAT_DEFAULT = 1;

    // Number of bytes touched by an access of the given size.
    function automatic int unsigned size_bytes(size_t sz);
        return 32'd8 >> sz;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bundle between the execute stage, the load/store unit and the memory.
// Wires only, no latency.
// req_valid is held by the requester until req_ready; memory side has no flow control.
interface load_store_unit_if;
    import lsu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    size_t       req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        resp_valid;
    logic [63:0] resp_rdata;

    logic [63:0] mem_raddress;
    logic [63:0] mem_waddress;
    logic [63:0] mem_datain;
    logic        mem_wr;
    size_t       mem_tam;
    logic [63:0] mem_dataout;

    // Requester plus memory: everything around the unit.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_raddress, mem_waddress, mem_datain, mem_wr, mem_tam,
        output mem_dataout
    );

    // The load/store unit itself.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata,
        output mem_raddress, mem_waddress, mem_datain, mem_wr, mem_tam,
        input  mem_dataout
    );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Extracts the low doubleword/word/half/byte of memory read data and sign- or zero-extends it to 64 bits.
// Purely combinational, zero latency.
// No flow control.
module load_extend
    import lsu_pkg::*;
(
    input  logic [63:0] raw,
    input  size_t       size,
    input  logic        is_unsigned,
    output logic [63:0] ext
);

    logic fill;

    // The memory already aligns the addressed byte to bit 0, so only the width and fill bit vary.
    always_comb begin
        ext  = raw;
        fill = 1'b0;
        case (size)
            SZ_W: begin
                fill = ~is_unsigned & raw[31];
                ext  = {{32{fill}}, raw[31:0]};
            end
            SZ_H: begin
                fill = ~is_unsigned & raw[15];
                ext  = {{48{fill}}, raw[15:0]};
            end
            SZ_B: begin
                fill = ~is_unsigned & raw[7];
                ext  = {{56{fill}}, raw[7:0]};
            end
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for the byte-banked 64-bit data memory.
// Store: mem_wr one cycle after accept, response one cycle later; load: response MEM_RD_LAT+2 cycles after accept.
// req_ready only in IDLE; requests offered while busy are ignored, nothing is queued.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_RD_LAT = MEM_RD_LAT_DEFAULT
) (
    input logic               Clk,
    input logic               reset,
    load_store_unit_if.slave  bus
);

    localparam int CNT_W = (MEM_RD_LAT < 1) ? 1 : $clog2(MEM_RD_LAT + 1);

    lsu_state_t         state;
    lsu_state_t         state_next;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    size_t              size_q;
    logic               uns_q;
    logic [63:0]        raddr_q;
    logic [63:0]        waddr_q;
    logic [63:0]        wdata_q;
    logic [63:0]        rdata_q;
    logic [63:0]        ext_data;

    assign accept = (state == IDLE) && bus.req_valid;

    // Next-state logic: a store spends one cycle driving the write, a load waits out the read latency.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.req_valid) state_next = bus.req_we ? STORE : LOAD_WAIT;
            STORE:     state_next = RESP;
            LOAD_WAIT: if (cnt == '0) state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // State register and read-latency countdown.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= CNT_W'(MEM_RD_LAT);
            end else if (state == LOAD_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Request capture; the memory-facing address/data registers hold until the next request of their kind.
    always_ff @(posedge Clk) begin
        if (reset) begin
            size_q  <= SZ_D;
            uns_q   <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            size_q <= bus.req_size;
            uns_q  <= bus.req_unsigned;
            if (bus.req_we) begin
                waddr_q <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end else begin
                raddr_q <= bus.req_addr;
            end
        end
    end

    load_extend u_extend (
        .raw         (bus.mem_dataout),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ext         (ext_data)
    );

    // Load result capture in the last wait cycle; holds until the next load completes.
    always_ff @(posedge Clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (state == LOAD_WAIT && cnt == '0) begin
            rdata_q <= ext_data;
        end
    end

    // Write enable is gated by reset so a reset landing in the store cycle drops the write.
    assign bus.req_ready    = (state == IDLE) && !reset;
    assign bus.resp_valid   = (state == RESP) && !reset;
    assign bus.resp_rdata   = rdata_q;
    assign bus.mem_wr       = (state == STORE) && !reset;
    assign bus.mem_raddress = raddr_q;
    assign bus.mem_waddress = waddr_q;
    assign bus.mem_datain   = wdata_q;
    assign bus.mem_tam      = size_q;

endmodule
